// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared widths, entry field layout and FSM states for the sprite line buffer
package sprite_pkg;

  localparam int SPR_ADDR_W     = 10;
  localparam int SPR_DATA_W     = 16;
  localparam int SPR_Z_MSB      = 9;
  localparam int SPR_Z_LSB      = 8;
  localparam int SPR_COLOUR_MSB = 7;
  localparam int SPR_COLOUR_LSB = 0;

  localparam logic [SPR_DATA_W-1:0] SPR_EMPTY = '0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lb_state_e;

  function automatic logic [SPR_DATA_W-1:0] spr_entry(input logic [1:0] z, input logic [7:0] colour);
    logic [SPR_DATA_W-1:0] e;
    e = SPR_EMPTY;
    e[SPR_Z_MSB:SPR_Z_LSB] = z;
    e[SPR_COLOUR_MSB:SPR_COLOUR_LSB] = colour;
    return e;
  endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// rtl/sprite_line_buffer_if.sv - renderer/composer/control bundle of the sprite line buffer
interface sprite_line_buffer_if
  import sprite_pkg::*;
#(
  parameter int ADDR_W = SPR_ADDR_W,
  parameter int DATA_W = SPR_DATA_W
);

  logic              swap;
  logic              init_done;
  logic [ADDR_W-1:0] spr_rdidx;
  logic [DATA_W-1:0] spr_rddata;
  logic [ADDR_W-1:0] spr_wridx;
  logic [DATA_W-1:0] spr_wrdata;
  logic              spr_wren;
  logic [ADDR_W-1:0] comp_rdidx;
  logic              comp_rden;
  logic [DATA_W-1:0] comp_rddata;
  logic              bank_sel;

  modport master (
    output swap, spr_rdidx, spr_wridx, spr_wrdata, spr_wren, comp_rdidx, comp_rden,
    input  init_done, spr_rddata, comp_rddata, bank_sel
  );

  modport slave (
    input  swap, spr_rdidx, spr_wridx, spr_wrdata, spr_wren, comp_rdidx, comp_rden,
    output init_done, spr_rddata, comp_rddata, bank_sel
  );

endinterface

// File: rtl/linebuf_bank.sv
// rtl/linebuf_bank.sv - one line bank: simple dual-port RAM, one write port, one registered read port
module linebuf_bank
  import sprite_pkg::*;
#(
  parameter int ADDR_W = SPR_ADDR_W,
  parameter int DATA_W = SPR_DATA_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read and write in the same edge: the read returns the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// rtl/sprite_line_buffer.sv - double-buffered sprite line store with post-reset clear and clear-on-read
// SPRITE_LINEBUF_FWD_EN: renderer read of the index being written in the same cycle returns the new data.
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int ADDR_W = SPR_ADDR_W,
  parameter int DATA_W = SPR_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_line_buffer_if.slave  bus
);

  lb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic              clr_pend_q, clr_bank_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              spr_vld_q, spr_bank_q;
  logic              fwd_hit_d, fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] comp_hold_q, comp_data;
  logic              run;

  logic              bank_we    [2];
  logic [ADDR_W-1:0] bank_waddr [2];
  logic [DATA_W-1:0] bank_wdata [2];
  logic [ADDR_W-1:0] bank_raddr [2];
  logic [DATA_W-1:0] bank_rdata [2];

  assign run = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    bank_sel_d = bank_sel_q ^ (run & bus.swap);
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      default: init_cnt_d = '0;
    endcase
  end

  // Single write port per bank: a pending clear takes the port ahead of any renderer write.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = init_cnt_q;
      bank_wdata[b] = '0;
      bank_raddr[b] = (bank_sel_q == 1'(b)) ? bus.spr_rdidx : bus.comp_rdidx;
      if (!run) begin
        bank_we[b] = 1'b1;
      end else if (clr_pend_q && (clr_bank_q == 1'(b))) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = clr_idx_q;
      end else if (bus.spr_wren && (bank_sel_q == 1'(b))) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = bus.spr_wridx;
        bank_wdata[b] = bus.spr_wrdata;
      end
    end
  end

`ifdef SPRITE_LINEBUF_FWD_EN
  assign fwd_hit_d = run && bus.spr_wren && (bus.spr_wridx == bus.spr_rdidx) &&
                     !(clr_pend_q && (clr_bank_q == bank_sel_q));
`else
  assign fwd_hit_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      bank_sel_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_bank_q  <= 1'b0;
      clr_idx_q   <= '0;
      spr_vld_q   <= 1'b0;
      spr_bank_q  <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      comp_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      bank_sel_q  <= bank_sel_d;
      clr_pend_q  <= run && bus.comp_rden;
      clr_bank_q  <= ~bank_sel_q;
      clr_idx_q   <= bus.comp_rdidx;
      spr_vld_q   <= run;
      spr_bank_q  <= bank_sel_q;
      fwd_hit_q   <= fwd_hit_d;
      fwd_data_q  <= bus.spr_wrdata;
      comp_hold_q <= comp_data;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    linebuf_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (bank_we[b]),
      .waddr_i (bank_waddr[b]),
      .wdata_i (bank_wdata[b]),
      .raddr_i (bank_raddr[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  // The composer read cycle doubles as the clear request, so its bank/valid come from the clear pipeline.
  assign comp_data       = clr_pend_q ? bank_rdata[clr_bank_q] : comp_hold_q;
  assign bus.comp_rddata = comp_data;
  assign bus.spr_rddata  = !spr_vld_q ? '0 : (fwd_hit_q ? fwd_data_q : bank_rdata[spr_bank_q]);
  assign bus.init_done   = run;
  assign bus.bank_sel    = bank_sel_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// tb/tb_sprite_line_buffer.sv - table-driven, scoreboarded bench for sprite_line_buffer
module tb_sprite_line_buffer;
  import sprite_pkg::*;

`ifdef SPRITE_LINEBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_line_buffer_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  sprite_line_buffer #(.ADDR_W(10), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    logic        sw;
    logic        we;
    logic [9:0]  widx;
    logic [15:0] wd;
    logic [9:0]  ridx;
    logic        cs;
    logic [15:0] es;
    logic        cre;
    logic [9:0]  cidx;
    logic        cc;
    logic [15:0] ec;
    logic        eb;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[21];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle();
    bus.swap = 1'b0; bus.spr_wren = 1'b0; bus.spr_wridx = '0; bus.spr_wrdata = '0;
    bus.spr_rdidx = '0; bus.comp_rden = 1'b0; bus.comp_rdidx = '0;
  endtask

  task automatic push(input int kind, input logic [15:0] exp);
    sb.push_back('{due: cyc + 1, kind: kind, exp: exp});
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       check("spr_rddata", {16'h0, bus.spr_rddata}, {16'h0, e.exp});
        1:       check("comp_rddata", {16'h0, bus.comp_rddata}, {16'h0, e.exp});
        default: check("bank_sel", {31'h0, bus.bank_sel}, {31'h0, e.exp[0]});
      endcase
    end
  endtask

  function automatic vec_t mk(input logic sw, input logic we, input logic [9:0] widx, input logic [15:0] wd,
                              input logic [9:0] ridx, input logic cs, input logic [15:0] es,
                              input logic cre, input logic [9:0] cidx, input logic cc, input logic [15:0] ec,
                              input logic eb);
    vec_t v;
    v.sw = sw; v.we = we; v.widx = widx; v.wd = wd; v.ridx = ridx; v.cs = cs; v.es = es;
    v.cre = cre; v.cidx = cidx; v.cc = cc; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    bus.swap = v.sw; bus.spr_wren = v.we; bus.spr_wridx = v.widx; bus.spr_wrdata = v.wd;
    bus.spr_rdidx = v.ridx; bus.comp_rden = v.cre; bus.comp_rdidx = v.cidx;
    if (v.cs) push(0, v.es);
    if (v.cc) push(1, v.ec);
    push(2, {15'h0, v.eb});
    tick();
  endtask

  // Both banks are read end to end through both ports; everything must be empty.
  task automatic sweep();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1024; i++) begin
        idle();
        bus.spr_rdidx = 10'(i); bus.comp_rden = 1'b1; bus.comp_rdidx = 10'(i);
        push(0, SPR_EMPTY);
        push(1, SPR_EMPTY);
        tick();
      end
      idle();
      bus.swap = 1'b1;
      tick();
    end
    idle();
  endtask

  // Reset, then run INIT to completion while poking inputs that must be ignored.
  task automatic do_reset(input int glitch_at);
    int cnt;
    int g;
    g = glitch_at;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_init_done", {31'h0, bus.init_done}, 32'h0);
    check("rst_bank_sel", {31'h0, bus.bank_sel}, 32'h0);
    check("rst_spr_rddata", {16'h0, bus.spr_rddata}, 32'h0);
    check("rst_comp_rddata", {16'h0, bus.comp_rddata}, 32'h0);
    cnt = 0;
    while (!bus.init_done && cnt < 3000) begin
      idle();
      if (cnt == g) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        g = -1;
        continue;
      end
      if (cnt == 10) begin
        bus.swap = 1'b1; bus.spr_wren = 1'b1; bus.spr_wridx = 10'd3; bus.spr_wrdata = 16'h00FF;
        bus.comp_rden = 1'b1; bus.comp_rdidx = 10'd3; bus.spr_rdidx = 10'd3;
      end
      if (cnt == 500) begin
        check("init_spr_rddata", {16'h0, bus.spr_rddata}, 32'h0);
        check("init_comp_rddata", {16'h0, bus.comp_rddata}, 32'h0);
      end
      tick();
      cnt++;
    end
    idle();
    check("init_len", cnt, 1024);
    check("init_done_high", {31'h0, bus.init_done}, 32'h1);
    check("init_bank_sel", {31'h0, bus.bank_sel}, 32'h0);
  endtask

  initial begin
    vecs[0]  = mk(0, 1,   10'd5, spr_entry(2'd2, 8'h34), 10'd0,    1, 16'h0000,          0, 10'd0,    0, 16'h0000, 0);
    vecs[1]  = mk(1, 0,   10'd0, 16'h0000,               10'd5,    1, 16'h0234,          1, 10'd5,    1, 16'h0000, 1);
    vecs[2]  = mk(0, 0,   10'd0, 16'h0000,               10'd5,    1, 16'h0000,          1, 10'd5,    1, 16'h0234, 1);
    vecs[3]  = mk(0, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          0, 10'd0,    1, 16'h0234, 1);
    vecs[4]  = mk(0, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          1, 10'd5,    1, 16'h0000, 1);
    vecs[5]  = mk(1, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          0, 10'd0,    0, 16'h0000, 0);
    vecs[6]  = mk(0, 1, 10'd1023, 16'h0377,              10'd0,    0, 16'h0000,          0, 10'd0,    0, 16'h0000, 0);
    vecs[7]  = mk(1, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          0, 10'd0,    0, 16'h0000, 1);
    vecs[8]  = mk(1, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          1, 10'd1023, 1, 16'h0377, 0);
    vecs[9]  = mk(0, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          0, 10'd0,    1, 16'h0377, 0);
    vecs[10] = mk(0, 0,   10'd0, 16'h0000,               10'd1023, 1, 16'h0000,          0, 10'd0,    0, 16'h0000, 0);
    vecs[11] = mk(1, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          0, 10'd0,    0, 16'h0000, 1);
    vecs[12] = mk(0, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          1, 10'd1023, 1, 16'h0000, 1);
    vecs[13] = mk(0, 1,   10'd7, 16'h0155,               10'd7,    1, FWD ? 16'h0155 : 16'h0000, 0, 10'd0, 0, 16'h0000, 1);
    vecs[14] = mk(0, 0,   10'd0, 16'h0000,               10'd7,    1, 16'h0155,          0, 10'd0,    0, 16'h0000, 1);
    vecs[15] = mk(1, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          1, 10'd9,    1, 16'h0000, 0);
    vecs[16] = mk(0, 1,   10'd9, 16'h0111,               10'd0,    0, 16'h0000,          0, 10'd0,    0, 16'h0000, 0);
    vecs[17] = mk(0, 0,   10'd0, 16'h0000,               10'd9,    1, 16'h0000,          0, 10'd0,    0, 16'h0000, 0);
    vecs[18] = mk(1, 1,  10'd11, 16'h0222,               10'd0,    0, 16'h0000,          0, 10'd0,    0, 16'h0000, 1);
    vecs[19] = mk(0, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          1, 10'd11,   1, 16'h0222, 1);
    vecs[20] = mk(0, 0,   10'd0, 16'h0000,               10'd0,    0, 16'h0000,          0, 10'd0,    1, 16'h0222, 1);

    idle();
    rst = 1'b1;
    do_reset(-1);
    sweep();

    for (int i = 0; i < 21; i++) begin
      apply_vec(vecs[i]);
    end
    idle();
    tick();

    // Leave a write and a clear in flight, reset in RUN, then glitch reset again mid-INIT.
    bus.spr_wren = 1'b1; bus.spr_wridx = 10'd20; bus.spr_wrdata = 16'h0333;
    bus.comp_rden = 1'b1; bus.comp_rdidx = 10'd11;
    tick();
    do_reset(300);
    sweep();

    tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
